// File: rtl/wb_queue.sv
// Writeback queue: buffers ALU/load register writes in a small FIFO, drains one
// per cycle onto the register file write port, and answers pending-write lookups.
module wb_queue #(
  parameter int WORD_WIDTH  = 32,
  parameter int REG_NUM_LOG = 5,
  parameter int DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        memValid,
  input  logic [REG_NUM_LOG-1:0]      memAddr,
  input  logic [WORD_WIDTH-1:0]       memValue,
  output logic                        memReady,
  input  logic                        aluValid,
  input  logic [REG_NUM_LOG-1:0]      aluAddr,
  input  logic [WORD_WIDTH-1:0]       aluValue,
  output logic                        aluReady,
  output logic                        writeEnable,
  output logic [REG_NUM_LOG-1:0]      writeAddr,
  output logic [WORD_WIDTH-1:0]       writeValue,
  input  logic [REG_NUM_LOG-1:0]      lookAddr1,
  input  logic [REG_NUM_LOG-1:0]      lookAddr2,
  output logic                        hit1,
  output logic                        hit2,
  output logic [WORD_WIDTH-1:0]       fwdValue1,
  output logic [WORD_WIDTH-1:0]       fwdValue2,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LIM1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LIM2 = CW'(DEPTH - 2);

  logic [REG_NUM_LOG-1:0] qaddr [DEPTH];
  logic [WORD_WIDTH-1:0]  qval  [DEPTH];
  logic [PW-1:0]          head, tail, alu_slot;
  logic                   mem_enq, alu_enq, deq;
  logic [CW-1:0]          enq_n;

  // Readiness looks only at the registered count, so a same-cycle drain never frees space.
  always_comb begin
    memReady = (count <= LIM1);
    aluReady = memValid ? (count <= LIM2) : (count <= LIM1);
    mem_enq  = memValid && memReady && (memAddr != '0);
    alu_enq  = aluValid && aluReady && (aluAddr != '0);
    enq_n    = CW'(mem_enq) + CW'(alu_enq);
    alu_slot = tail + PW'(mem_enq);
    deq      = (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      writeEnable <= 1'b0;
      writeAddr   <= '0;
      writeValue  <= '0;
    end else begin
      tail  <= tail + PW'(enq_n);
      count <= count + enq_n - CW'(deq);
      if (deq) begin
        writeEnable <= 1'b1;
        writeAddr   <= qaddr[head];
        writeValue  <= qval[head];
        head        <= head + PW'(1);
      end else begin
        writeEnable <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_enq) begin
      qaddr[tail] <= memAddr;
      qval[tail]  <= memValue;
    end
    if (alu_enq) begin
      qaddr[alu_slot] <= aluAddr;
      qval[alu_slot]  <= aluValue;
    end
  end

  // Oldest candidate first (write-port register, then queue from head), so the
  // last match written is the youngest pending value.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    fwdValue1 = '0;
    fwdValue2 = '0;
    if (writeEnable && lookAddr1 != '0 && writeAddr == lookAddr1) begin
      hit1      = 1'b1;
      fwdValue1 = writeValue;
    end
    if (writeEnable && lookAddr2 != '0 && writeAddr == lookAddr2) begin
      hit2      = 1'b1;
      fwdValue2 = writeValue;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (lookAddr1 != '0 && qaddr[head + PW'(k)] == lookAddr1) begin
          hit1      = 1'b1;
          fwdValue1 = qval[head + PW'(k)];
        end
        if (lookAddr2 != '0 && qaddr[head + PW'(k)] == lookAddr2) begin
          hit2      = 1'b1;
          fwdValue2 = qval[head + PW'(k)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue with a small FIFO scoreboard for streams.
module tb_wb_queue;
  localparam int W = 32;
  localparam int A = 5;
  localparam int D = 4;

  typedef struct packed {
    logic [A-1:0] a;
    logic [W-1:0] v;
  } req_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         memValid = 1'b0, aluValid = 1'b0;
  logic [A-1:0] memAddr = '0, aluAddr = '0;
  logic [W-1:0] memValue = '0, aluValue = '0;
  logic         memReady, aluReady;
  logic         writeEnable;
  logic [A-1:0] writeAddr;
  logic [W-1:0] writeValue;
  logic [A-1:0] lookAddr1 = '0, lookAddr2 = '0;
  logic         hit1, hit2;
  logic [W-1:0] fwdValue1, fwdValue2;
  logic [2:0]   count;

  int checks = 0;
  int failures = 0;

  req_t mq[$];
  req_t aq[$];
  req_t sq[$];

  wb_queue #(.WORD_WIDTH(W), .REG_NUM_LOG(A), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .memValid(memValid), .memAddr(memAddr), .memValue(memValue), .memReady(memReady),
    .aluValid(aluValid), .aluAddr(aluAddr), .aluValue(aluValue), .aluReady(aluReady),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeValue(writeValue),
    .lookAddr1(lookAddr1), .lookAddr2(lookAddr2),
    .hit1(hit1), .hit2(hit2), .fwdValue1(fwdValue1), .fwdValue2(fwdValue2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    memValid = 1'b0;
    aluValid = 1'b0;
  endtask

  // Present queued requests, holding each until accepted; check readies, drain and count.
  task automatic run_stream(input string tag);
    int   cyc = 0;
    req_t r;
    logic em, ea, dexp;
    while ((mq.size() > 0 || aq.size() > 0 || sq.size() > 0) && cyc < 100) begin
      memValid = (mq.size() > 0);
      if (memValid) begin
        r = mq[0];
        memAddr = r.a;
        memValue = r.v;
      end
      aluValid = (aq.size() > 0);
      if (aluValid) begin
        r = aq[0];
        aluAddr = r.a;
        aluValue = r.v;
      end
      #1;
      em = (sq.size() <= D - 1);
      ea = memValid ? (sq.size() <= D - 2) : (sq.size() <= D - 1);
      chk({tag, "_memReady"}, memReady, em);
      chk({tag, "_aluReady"}, aluReady, ea);
      dexp = (sq.size() > 0);
      if (dexp) r = sq.pop_front();
      if (memValid && em) sq.push_back(mq.pop_front());
      if (aluValid && ea) sq.push_back(aq.pop_front());
      tick;
      chk({tag, "_we"}, writeEnable, dexp);
      if (dexp) begin
        chk({tag, "_waddr"}, writeAddr, r.a);
        chk({tag, "_wvalue"}, writeValue, r.v);
      end
      chk({tag, "_count"}, count, sq.size());
      cyc++;
    end
    idle;
    if (cyc >= 100) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=<100", tag, cyc);
    end
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_we", writeEnable, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_memReady", memReady, 1'b1);
    chk("rst_aluReady", aluReady, 1'b1);
    tick;
    tick;
    rst = 1'b0;

    // single write
    aluValid = 1'b1; aluAddr = 5'd3; aluValue = 32'h11; lookAddr1 = 5'd3;
    #1;
    chk("single_aluReady", aluReady, 1'b1);
    chk("single_hit_before", hit1, 1'b0);
    tick; idle;
    chk("single_count1", count, 3'd1);
    chk("single_we0", writeEnable, 1'b0);
    chk("single_hit_q", hit1, 1'b1);
    chk("single_fwd_q", fwdValue1, 32'h11);
    tick;
    chk("single_we1", writeEnable, 1'b1);
    chk("single_waddr", writeAddr, 5'd3);
    chk("single_wvalue", writeValue, 32'h11);
    chk("single_count0", count, 3'd0);
    chk("single_hit_wp", hit1, 1'b1);
    tick;
    chk("single_we_off", writeEnable, 1'b0);
    chk("single_hit_gone", hit1, 1'b0);
    chk("single_waddr_hold", writeAddr, 5'd3);

    // dual accept ordering
    memValid = 1'b1; memAddr = 5'd5; memValue = 32'hA;
    aluValid = 1'b1; aluAddr = 5'd5; aluValue = 32'hB; lookAddr1 = 5'd5;
    #1;
    chk("dual_memReady", memReady, 1'b1);
    chk("dual_aluReady", aluReady, 1'b1);
    tick; idle;
    chk("dual_count", count, 3'd2);
    chk("dual_fwd_pre", fwdValue1, 32'hB);
    tick;
    chk("dual_w1_addr", writeAddr, 5'd5);
    chk("dual_w1_value", writeValue, 32'hA);
    chk("dual_fwd_mid", fwdValue1, 32'hB);
    tick;
    chk("dual_w2_we", writeEnable, 1'b1);
    chk("dual_w2_value", writeValue, 32'hB);
    chk("dual_fwd_wp", fwdValue1, 32'hB);
    tick;
    chk("dual_we_off", writeEnable, 1'b0);
    chk("dual_hit_gone", hit1, 1'b0);

    // address zero
    aluValid = 1'b1; aluAddr = 5'd0; aluValue = 32'hFF; lookAddr1 = 5'd0; lookAddr2 = 5'd0;
    #1;
    chk("zero_aluReady", aluReady, 1'b1);
    tick; idle;
    chk("zero_count", count, 3'd0);
    chk("zero_hit1", hit1, 1'b0);
    chk("zero_hit2", hit2, 1'b0);
    tick;
    chk("zero_we", writeEnable, 1'b0);
    // load to r0 alongside a real ALU write: only the ALU entry is queued
    memValid = 1'b1; memAddr = 5'd0; memValue = 32'h99;
    aluValid = 1'b1; aluAddr = 5'd4; aluValue = 32'h44; lookAddr2 = 5'd4;
    tick; idle;
    chk("zero_mix_count", count, 3'd1);
    chk("zero_mix_hit2", hit2, 1'b1);
    chk("zero_mix_fwd2", fwdValue2, 32'h44);
    tick;
    chk("zero_mix_waddr", writeAddr, 5'd4);
    chk("zero_mix_wvalue", writeValue, 32'h44);
    tick;

    // full / backpressure: 8 loads and 8 ALU writes held until accepted
    for (int i = 1; i <= 8; i++) begin
      mq.push_back('{a: A'(i), v: 32'h100 + i});
      aq.push_back('{a: A'(i + 8), v: 32'h200 + i});
    end
    run_stream("full");
    tick;
    chk("full_we_off", writeEnable, 1'b0);

    // wrap: r1 via load + r2..r10 via ALU keeps two entries in flight
    mq.push_back('{a: 5'd1, v: 32'h301});
    for (int i = 2; i <= 10; i++) aq.push_back('{a: A'(i), v: 32'h300 + i});
    run_stream("wrap");
    tick;
    tick;

    // reset mid-drain
    memValid = 1'b1; memAddr = 5'd7; memValue = 32'h77;
    aluValid = 1'b1; aluAddr = 5'd8; aluValue = 32'h88; lookAddr1 = 5'd8;
    tick; idle;
    tick;
    chk("rstmid_we_pre", writeEnable, 1'b1);
    chk("rstmid_waddr_pre", writeAddr, 5'd7);
    #1;
    chk("rstmid_hit_pre", hit1, 1'b1);
    chk("rstmid_fwd_pre", fwdValue1, 32'h88);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_we", writeEnable, 1'b0);
    chk("rstmid_count", count, 3'd0);
    chk("rstmid_memReady", memReady, 1'b1);
    chk("rstmid_aluReady", aluReady, 1'b1);
    chk("rstmid_hit1", hit1, 1'b0);
    chk("rstmid_waddr", writeAddr, 5'd0);
    #1 rst = 1'b0;
    tick;
    chk("rstmid_we_after", writeEnable, 1'b0);
    chk("rstmid_count_after", count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
